// File: rtl/spi_frame_writer.sv
// SPI mode-0 slave exposing a bank of 8-bit LED frame registers.
// All SPI pins are oversampled in clk; the address width must satisfy 2**ADDR_W >= MEMORY_COUNT.
module spi_frame_writer #(
    parameter int MEMORY_COUNT = 12,
    parameter int ADDR_W       = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      spi_sclk,
    input  logic                      spi_mosi,
    input  logic                      spi_cs_n,
    output logic                      spi_miso,
    output logic                      spi_miso_oe,
    output logic [8*MEMORY_COUNT-1:0] mem_flat,
    output logic                      wr_strobe,
    output logic [ADDR_W-1:0]         wr_addr
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CMD   = 2'd1;
    localparam logic [1:0] ST_WDATA = 2'd2;
    localparam logic [1:0] ST_RDATA = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEMORY_COUNT - 1);

    logic [1:0]        sclk_sync_reg;
    logic [1:0]        mosi_sync_reg;
    logic [1:0]        cs_n_sync_reg;
    logic              sclk_prev_reg;
    logic              cs_n_prev_reg;

    logic [1:0]        state_reg;
    logic [3:0]        bit_cnt_reg;
    logic [6:0]        shift_in_reg;
    logic [7:0]        shift_out_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              wr_strobe_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [7:0]        wr_data_reg;

    logic              sclk_s;
    logic              cs_n_s;
    logic              sclk_rise;
    logic              sclk_fall;
    logic              cs_fall;
    logic [7:0]        byte_next;
    logic [ADDR_W-1:0] addr_inc;
    logic              addr_in_range;
    logic [7:0]        rd_cmd_byte;
    logic [7:0]        rd_next_byte;

    // cs_n synchronizer resets to its idle (deasserted) level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_reg <= 2'b00;
            mosi_sync_reg <= 2'b00;
            cs_n_sync_reg <= 2'b11;
            sclk_prev_reg <= 1'b0;
            cs_n_prev_reg <= 1'b1;
        end else begin
            sclk_sync_reg <= {sclk_sync_reg[0], spi_sclk};
            mosi_sync_reg <= {mosi_sync_reg[0], spi_mosi};
            cs_n_sync_reg <= {cs_n_sync_reg[0], spi_cs_n};
            sclk_prev_reg <= sclk_sync_reg[1];
            cs_n_prev_reg <= cs_n_sync_reg[1];
        end
    end

    assign sclk_s    = sclk_sync_reg[1];
    assign cs_n_s    = cs_n_sync_reg[1];
    assign sclk_rise = sclk_s & ~sclk_prev_reg;
    assign sclk_fall = ~sclk_s & sclk_prev_reg;
    assign cs_fall   = ~cs_n_s & cs_n_prev_reg;
    assign byte_next = {shift_in_reg, mosi_sync_reg[1]};

    assign addr_inc      = (addr_reg == LAST_ADDR) ? '0 : addr_reg + ADDR_W'(1);
    assign addr_in_range = (int'(addr_reg) < MEMORY_COUNT);

    // Readback mux; addresses past the register file read as zero
    always_comb begin
        rd_cmd_byte  = 8'h00;
        rd_next_byte = 8'h00;
        for (int i = 0; i < MEMORY_COUNT; i++) begin
            if (byte_next[ADDR_W-1:0] == ADDR_W'(i))
                rd_cmd_byte = mem_flat[8*i +: 8];
            if (addr_inc == ADDR_W'(i))
                rd_next_byte = mem_flat[8*i +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= 4'd0;
            shift_in_reg  <= 7'd0;
            shift_out_reg <= 8'h00;
            addr_reg      <= '0;
            wr_strobe_reg <= 1'b0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= 8'h00;
        end else begin
            wr_strobe_reg <= 1'b0;
            if (cs_n_s) begin
                // Deselect wins over any byte completing in the same cycle
                state_reg   <= ST_IDLE;
                bit_cnt_reg <= 4'd0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (cs_fall) begin
                            state_reg   <= ST_CMD;
                            bit_cnt_reg <= 4'd0;
                        end
                    end
                    ST_CMD: begin
                        if (sclk_rise) begin
                            shift_in_reg <= byte_next[6:0];
                            if (bit_cnt_reg == 4'd7) begin
                                bit_cnt_reg <= 4'd0;
                                addr_reg    <= byte_next[ADDR_W-1:0];
                                if (byte_next[7]) begin
                                    state_reg <= ST_WDATA;
                                end else begin
                                    state_reg     <= ST_RDATA;
                                    shift_out_reg <= rd_cmd_byte;
                                end
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 4'd1;
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (sclk_rise) begin
                            shift_in_reg <= byte_next[6:0];
                            if (bit_cnt_reg == 4'd7) begin
                                bit_cnt_reg <= 4'd0;
                                if (addr_in_range) begin
                                    wr_strobe_reg <= 1'b1;
                                    wr_addr_reg   <= addr_reg;
                                    wr_data_reg   <= byte_next;
                                end
                                addr_reg <= addr_inc;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 4'd1;
                            end
                        end
                    end
                    default: begin
                        // bit_cnt counts rises of the current byte; the trailing
                        // fall of the command byte arrives with a count of zero
                        if (sclk_rise && bit_cnt_reg != 4'd8) begin
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        end else if (sclk_fall) begin
                            if (bit_cnt_reg == 4'd8) begin
                                bit_cnt_reg   <= 4'd0;
                                addr_reg      <= addr_inc;
                                shift_out_reg <= rd_next_byte;
                            end else if (bit_cnt_reg != 4'd0) begin
                                shift_out_reg <= {shift_out_reg[6:0], 1'b0};
                            end
                        end
                    end
                endcase
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < MEMORY_COUNT; gi++) begin : g_reg
            logic [7:0] value_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    value_reg <= 8'h00;
                else if (wr_strobe_reg && wr_addr_reg == ADDR_W'(gi))
                    value_reg <= wr_data_reg;
            end
            assign mem_flat[8*gi +: 8] = value_reg;
        end
    endgenerate

    assign spi_miso_oe = (state_reg == ST_RDATA);
    assign spi_miso    = spi_miso_oe & shift_out_reg[7];
    assign wr_strobe   = wr_strobe_reg;
    assign wr_addr     = wr_addr_reg;

endmodule

// File: tb/tb_spi_frame_writer.sv
// Bench for spi_frame_writer: directed frames plus random bursts against a register-file model.
module tb_spi_frame_writer;

    localparam int MEMORY_COUNT = 12;
    localparam int ADDR_W       = 4;
    localparam int HALF         = 5;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      spi_sclk;
    logic                      spi_mosi;
    logic                      spi_cs_n;
    logic                      spi_miso;
    logic                      spi_miso_oe;
    logic [8*MEMORY_COUNT-1:0] mem_flat;
    logic                      wr_strobe;
    logic [ADDR_W-1:0]         wr_addr;

    spi_frame_writer #(.MEMORY_COUNT(MEMORY_COUNT), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .spi_sclk    (spi_sclk),
        .spi_mosi    (spi_mosi),
        .spi_cs_n    (spi_cs_n),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .mem_flat    (mem_flat),
        .wr_strobe   (wr_strobe),
        .wr_addr     (wr_addr)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         txn_id   = 0;
    logic [7:0] model_mem [MEMORY_COUNT];
    int         strobe_q [$];
    int         exp_q [$];
    logic [7:0] tx_buf [8];
    logic [7:0] rx_dummy;

    // Every cycle the strobe is high logs one entry, so a stretched pulse shows up
    always @(negedge clk) begin
        if (!rst && wr_strobe) strobe_q.push_back(int'(wr_addr));
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int next_addr(input int a);
        if (a == MEMORY_COUNT - 1) return 0;
        return (a + 1) % (1 << ADDR_W);
    endfunction

    function automatic logic [127:0] model_flat();
        logic [127:0] f = '0;
        for (int i = 0; i < MEMORY_COUNT; i++) f[8*i +: 8] = model_mem[i];
        return f;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Master side of mode 0: data set while SCLK low, MISO captured just before each rise
    task automatic spi_bits(input logic [7:0] tx, input int nbits, input bit chk_oe,
                            output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = tx[7-i];
            tick(HALF);
            rx = {rx[6:0], spi_miso};
            if (chk_oe && i == 0) check("miso_oe_rdata", 128'(spi_miso_oe), 128'd1);
            spi_sclk = 1'b1;
            tick(HALF);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic frame_start();
        spi_cs_n = 1'b0;
        tick(6);
    endtask

    task automatic frame_end();
        tick(6);
        spi_cs_n = 1'b1;
        tick(8);
    endtask

    task automatic verify_writes();
        check("strobe_count", 128'(strobe_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < strobe_q.size() && i < exp_q.size(); i++)
            check("strobe_addr", 128'(strobe_q[i]), 128'(exp_q[i]));
        check("mem_flat", 128'(mem_flat), model_flat());
        strobe_q.delete();
        exp_q.delete();
    endtask

    task automatic write_txn(input logic [7:0] cmd, input int n);
        int a;
        txn_id++;
        $display("txn %0d: write cmd=%02h bytes=%0d", txn_id, cmd, n);
        frame_start();
        spi_bits(cmd, 8, 1'b0, rx_dummy);
        a = int'(cmd[ADDR_W-1:0]);
        for (int i = 0; i < n; i++) begin
            spi_bits(tx_buf[i], 8, 1'b0, rx_dummy);
            if (a < MEMORY_COUNT) begin
                model_mem[a] = tx_buf[i];
                exp_q.push_back(a);
            end
            a = next_addr(a);
        end
        frame_end();
        verify_writes();
    endtask

    task automatic read_txn(input logic [7:0] cmd, input int n);
        int         a;
        logic [7:0] rx;
        logic [7:0] exp;
        txn_id++;
        $display("txn %0d: read  cmd=%02h bytes=%0d", txn_id, cmd, n);
        frame_start();
        spi_bits(cmd, 8, 1'b0, rx_dummy);
        a = int'(cmd[ADDR_W-1:0]);
        for (int i = 0; i < n; i++) begin
            spi_bits(8'($urandom), 8, 1'b1, rx);
            exp = (a < MEMORY_COUNT) ? model_mem[a] : 8'h00;
            check("rd_data", 128'(rx), 128'(exp));
            a = next_addr(a);
        end
        frame_end();
        check("miso_oe_idle", 128'(spi_miso_oe), 128'd0);
        verify_writes();
    endtask

    initial begin
        for (int i = 0; i < MEMORY_COUNT; i++) model_mem[i] = 8'h00;
        rst      = 1'b1;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        spi_cs_n = 1'b1;
        tick(3);
        check("rst_mem_flat", 128'(mem_flat), 128'd0);
        check("rst_miso", 128'(spi_miso), 128'd0);
        check("rst_miso_oe", 128'(spi_miso_oe), 128'd0);
        check("rst_wr_strobe", 128'(wr_strobe), 128'd0);
        check("rst_wr_addr", 128'(wr_addr), 128'd0);
        rst = 1'b0;
        tick(4);

        tx_buf[0] = 8'hA5; tx_buf[1] = 8'h3C;
        write_txn(8'h80, 2);

        tx_buf[0] = 8'h11; tx_buf[1] = 8'h22; tx_buf[2] = 8'h33;
        write_txn(8'h8B, 3);

        tx_buf[0] = 8'hFF;
        write_txn(8'h8E, 1);
        read_txn(8'h0E, 1);

        tx_buf[0] = 8'h5A; tx_buf[1] = 8'hC3;
        write_txn(8'h82, 2);
        read_txn(8'h02, 2);

        // Deselect after 5 bits of a data byte: nothing may be written
        txn_id++;
        $display("txn %0d: write cmd=80 aborted after 5 data bits", txn_id);
        frame_start();
        spi_bits(8'h80, 8, 1'b0, rx_dummy);
        spi_bits(8'hF0, 5, 1'b0, rx_dummy);
        frame_end();
        verify_writes();
        tx_buf[0] = 8'h77;
        write_txn(8'h80, 1);
        read_txn(8'h0B, 3);

        // Reset in the middle of a write frame
        txn_id++;
        $display("txn %0d: reset asserted mid-frame", txn_id);
        frame_start();
        spi_bits(8'h80, 8, 1'b0, rx_dummy);
        spi_bits(8'h12, 4, 1'b0, rx_dummy);
        rst = 1'b1;
        tick(2);
        check("midrst_mem_flat", 128'(mem_flat), 128'd0);
        check("midrst_miso_oe", 128'(spi_miso_oe), 128'd0);
        check("midrst_wr_strobe", 128'(wr_strobe), 128'd0);
        for (int i = 0; i < MEMORY_COUNT; i++) model_mem[i] = 8'h00;
        spi_cs_n = 1'b1;
        spi_sclk = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(4);
        strobe_q.delete();
        exp_q.delete();
        tx_buf[0] = 8'h99;
        write_txn(8'h84, 1);
        read_txn(8'h04, 1);

        for (int t = 0; t < 30; t++) begin
            logic [7:0] cmd;
            int         n;
            cmd = 8'($urandom);
            n   = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) tx_buf[i] = 8'($urandom);
            if (cmd[7]) write_txn(cmd, n);
            else        read_txn(cmd, n);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
